// File: rtl/asic_iopoc_pkg.sv
// Shared types for the IO-ring power-on-control sequencer: FSM state encoding
// and the counter-width helper sized from the longest timed phase.
package asic_iopoc_pkg;

    typedef enum logic [2:0] {
        OFF      = 3'd0,
        DEBOUNCE = 3'd1,
        HOLD     = 3'd2,
        STAGE    = 3'd3,
        READY    = 3'd4,
        SHUTDOWN = 3'd5,
        FAULT    = 3'd6
    } state_e;

    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/asic_iopoc_sync.sv
// Two-flop synchronizer for an asynchronous supply-good flag (no reset, so the
// chain keeps tracking the detector even while the sequencer is held in reset).
module asic_iopoc_sync (
    input  logic clk,
    input  logic d,
    output logic q
);

    logic s1_q;
    logic s2_q;

    always_ff @(posedge clk) begin
        s1_q <= d;
        s2_q <= s1_q;
    end

    assign q = s2_q;

endmodule

// File: rtl/asic_iopoc_seq.sv
// IO-ring power-on-control sequencer: holds pads safe until supplies are good,
// then stages pad groups on/off. Optional macro IOPOC_FAULT_LATCH_EN latches brown-out faults.
module asic_iopoc_seq
    import asic_iopoc_pkg::*;
#(
    parameter int NGROUPS         = 4,
    parameter int DEBOUNCE_CYCLES = 64,
    parameter int HOLD_CYCLES     = 16,
    parameter int STAGE_CYCLES    = 8
) (
    input  logic               clk,
    input  logic               nreset,
    input  logic               en,
    input  logic               vdd_ok,
    input  logic               vddio_ok,
    input  logic               fault_clr,
    output logic               poc,
    output logic [NGROUPS-1:0] grp_en,
    output logic               ready,
    output logic               fault,
    output state_e             dbg_state
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES, HOLD_CYCLES, STAGE_CYCLES);
    localparam logic [CW-1:0]      DEB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0]      HOLD_LAST  = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0]      STAGE_LAST = CW'(STAGE_CYCLES - 1);
    localparam logic [NGROUPS-1:0] ALL_ON     = '1;

    logic vdd_s;
    logic vddio_s;
    logic pgood;
    logic brown_out;
    logic [NGROUPS-1:0] grp_up;

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               poc_q, poc_d;
    logic [NGROUPS-1:0] grp_en_q, grp_en_d;
    logic               ready_q, ready_d;
    logic               fault_q, fault_d;

    asic_iopoc_sync u_sync_vdd   (.clk(clk), .d(vdd_ok),   .q(vdd_s));
    asic_iopoc_sync u_sync_vddio (.clk(clk), .d(vddio_ok), .q(vddio_s));

    assign pgood     = vdd_s & vddio_s;
    assign brown_out = !pgood && (state_q inside {HOLD, STAGE, READY, SHUTDOWN});
    // Groups fill as a thermometer code, so the next enable is a shift-in of a one.
    assign grp_up    = (grp_en_q << 1) | NGROUPS'(1);

`ifndef IOPOC_FAULT_LATCH_EN
    logic unused_fault_clr;
    assign unused_fault_clr = fault_clr;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        poc_d    = poc_q;
        grp_en_d = grp_en_q;
        ready_d  = ready_q;
`ifdef IOPOC_FAULT_LATCH_EN
        fault_d  = fault_q;
`else
        fault_d  = 1'b0;
`endif
        if (brown_out) begin
            poc_d    = 1'b1;
            grp_en_d = '0;
            ready_d  = 1'b0;
            fault_d  = 1'b1;
`ifdef IOPOC_FAULT_LATCH_EN
            state_d  = FAULT;
`else
            state_d  = OFF;
`endif
        end else begin
            case (state_q)
                OFF: begin
                    if (en && pgood) state_d = DEBOUNCE;
                end
                DEBOUNCE: begin
                    if (!pgood || !en) begin
                        state_d = OFF;
                    end else if (cnt_q == DEB_LAST) begin
                        state_d = HOLD;
                        poc_d   = 1'b0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        state_d  = STAGE;
                        grp_en_d = NGROUPS'(1);
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                STAGE: begin
                    // Only a single-group ring can arrive here already full.
                    if (grp_en_q == ALL_ON) begin
                        state_d = READY;
                        ready_d = 1'b1;
                    end else if (cnt_q == STAGE_LAST) begin
                        grp_en_d = grp_up;
                        cnt_d    = '0;
                        if (grp_up == ALL_ON) begin
                            state_d = READY;
                            ready_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                READY: begin
                    if (!en) begin
                        state_d = SHUTDOWN;
                        ready_d = 1'b0;
                    end
                end
                SHUTDOWN: begin
                    if (cnt_q == STAGE_LAST) begin
                        cnt_d = '0;
                        if (grp_en_q != '0) begin
                            grp_en_d = grp_en_q >> 1;
                        end else begin
                            state_d = OFF;
                            poc_d   = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                FAULT: begin
`ifdef IOPOC_FAULT_LATCH_EN
                    if (fault_clr && pgood) begin
                        state_d = OFF;
                        fault_d = 1'b0;
                    end
`else
                    state_d = OFF;
`endif
                end
                default: state_d = OFF;
            endcase
        end
        if (state_d != state_q) cnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q  <= OFF;
            cnt_q    <= '0;
            poc_q    <= 1'b1;
            grp_en_q <= '0;
            ready_q  <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            poc_q    <= poc_d;
            grp_en_q <= grp_en_d;
            ready_q  <= ready_d;
            fault_q  <= fault_d;
        end
    end

    assign poc       = poc_q;
    assign grp_en    = grp_en_q;
    assign ready     = ready_q;
    assign fault     = fault_q;
    assign dbg_state = state_q;

endmodule
